omsp_status_reg: RTL and testbench
==================================

// Module: omsp_status_reg
// PURPOSE
// - R2 status register and low-power-mode sequencer; consumes ALU flag updates {V,N,Z,C} + write strobes.
// - Feeds current flags back to the ALU and decoder (jump conditions, ADDC/SUBC/DADD/RRC carry-in).
// - Drives clock-module LPM request/ack handshake from CPUOFF; wakes on pending IRQ or debug.
// PARAMETERS
// - LPM_EN        1     1: CPUOFF drives the LPM handshake; 0: CPUOFF bit stored, lpm_req tied 0
// - SR_RSVD_MASK  16'h0000  writable mask for reserved bits 15:9; masked bits read 0
// PORTS
// - mclk         in   1   CPU main clock; single clock domain
// - puc_rst      in   1   synchronous active-high reset
// - alu_stat     in   4   ALU flag values {V,N,Z,C}
// - alu_stat_wr  in   4   per-flag write strobes {V,N,Z,C}
// - sr_wr        in   1   register-file write to R2 (MOV/ADD/... dst=SR, RETI SR pop)
// - sr_wdata     in   16  data for sr_wr
// - irq_entry    in   1   interrupt acknowledge cycle (SR already pushed)
// - irq_pnd      in   1   maskable IRQ pending (before GIE gating)
// - nmi_pnd      in   1   non-maskable IRQ pending
// - dbg_halt_st  in   1   CPU halted by debug unit
// - dbg_wake     in   1   debug request to leave LPM
// - lpm_ack      in   1   clock module: CPU clock gated (LPM) when 1
// - status       out  4   {V,N,Z,C} to ALU / decoder
// - sr           out  16  full R2 readback value
// - gie, cpu_off, osc_off, scg0, scg1  out 1 each  decoded SR control bits
// - lpm_req      out  1   request CPU clock gating
// - cpu_en       out  1   1 = fetch/execute allowed
// BEHAVIOUR
// - Bit map: C=0 Z=1 N=2 GIE=3 CPUOFF=4 OSCOFF=5 SCG0=6 SCG1=7 V=8; 15:9 reserved.
// - Reset: sr=16'h0000, status=4'h0, all control outs 0, lpm_req=0, cpu_en=1, FSM=RUN.
// - Update priority per cycle, highest first:
//   1 irq_entry: clear every bit except SCG0 (SCG0 held).
//   2 sr_wr: sr <= sr_wdata, reserved bits per SR_RSVD_MASK; ignores alu_stat_wr same cycle.
//   3 alu_stat_wr[i]: flag i <= alu_stat[i]; unstrobed flags hold.
// - Latency: all writes visible on status/sr the cycle after the strobe; no bypass.
// - FSM (LPM_EN=1), state register only:
//   RUN:   cpu_en=1, lpm_req=0; -> REQ when cpu_off & ~dbg_halt_st & ~wake.
//   REQ:   cpu_en=0, lpm_req=1; -> SLEEP on lpm_ack; -> EXIT if wake first.
//   SLEEP: cpu_en=0, lpm_req=1; -> EXIT on wake.
//   EXIT:  cpu_en=0, lpm_req=0; -> RUN when lpm_ack=0.
//   wake = (irq_pnd & gie) | nmi_pnd | dbg_wake.
// - cpu_off cleared by sr_wr/irq_entry while in SLEEP does not bypass the handshake; exit is
//   still via EXIT and lpm_ack=0.
// - dbg_halt_st=1 in RUN blocks REQ entry; already in REQ/SLEEP it has no effect.
// - puc_rst mid-handshake: FSM -> RUN, lpm_req -> 0 next edge, independent of lpm_ack.
// - LPM_EN=0: FSM stays RUN, cpu_en=1 permanently.
// STRUCTURE
// - Shared defines file: SR bit indices (`C,`Z,`N,`GIE,`CPUOFF,`OSCOFF,`SCG0,`SCG1,`V) and
//   FSM state encodings (2-bit).
// - Sub-module omsp_lpm_fsm: the 4-state handshake sequencer.
// - SR register and priority mux stay in this top.
// TESTING
// - alu_stat=4'b1011, alu_stat_wr=4'b0101 from sr=0 -> next cycle status=4'b0001, sr=16'h0001.
// - sr_wr=1, sr_wdata=16'h01FF, and alu_stat_wr=4'hF with alu_stat=4'h0 in the same cycle
//   -> sr=16'h01FF, status=4'b1111.
// - sr=16'h00F9 (SCG1,SCG0,OSCOFF,CPUOFF,GIE,C set), irq_entry=1 -> sr=16'h0040.
// - LPM entry/exit, with sr_wr 16'h0018 (GIE+CPUOFF):
//   - RUN->REQ: lpm_req=1, cpu_en=0.
//   - lpm_ack=1 -> SLEEP.
//   - irq_pnd=1 -> lpm_req=0; lpm_ack=0 -> cpu_en=1 one cycle later.
//   - Same with GIE=0: irq_pnd ignored; nmi_pnd=1 wakes.
// - dbg_halt_st=1 with CPUOFF=1 -> lpm_req stays 0; drop dbg_halt_st -> REQ next cycle.
// - puc_rst asserted in SLEEP with lpm_ack=1 -> next cycle lpm_req=0, cpu_en=1, sr=0.

Source files
------------

// File: rtl/omsp_status_reg_pkg.sv
// Shared definitions for the R2 status register: SR bit positions,
// write/retention masks and the low-power-mode handshake state encoding.
package omsp_status_reg_pkg;

  localparam int unsigned SR_C      = 0;
  localparam int unsigned SR_Z      = 1;
  localparam int unsigned SR_N      = 2;
  localparam int unsigned SR_GIE    = 3;
  localparam int unsigned SR_CPUOFF = 4;
  localparam int unsigned SR_OSCOFF = 5;
  localparam int unsigned SR_SCG0   = 6;
  localparam int unsigned SR_SCG1   = 7;
  localparam int unsigned SR_V      = 8;

  // Architected bits 8:0 are always writable; reserved bits 15:9 are
  // writable only where the instance mask enables them.
  localparam logic [15:0] SR_ARCH_WMASK = 16'h01FF;
  localparam logic [15:0] SR_RSVD_BITS  = 16'hFE00;

  // Interrupt entry keeps only SCG0.
  localparam logic [15:0] SR_IRQ_KEEP   = 16'h0040;

  typedef enum logic [1:0] {
    LPM_RUN   = 2'b00,
    LPM_REQ   = 2'b01,
    LPM_SLEEP = 2'b10,
    LPM_EXIT  = 2'b11
  } lpm_state_e;

  // {V,N,Z,C} view of a full SR value.
  function automatic logic [3:0] sr_flags(input logic [15:0] sr_val);
    return {sr_val[SR_V], sr_val[SR_N], sr_val[SR_Z], sr_val[SR_C]};
  endfunction

endpackage

// File: rtl/omsp_lpm_fsm.sv
// Low-power-mode request/acknowledge sequencer between the CPU and the
// clock module. Outputs are decoded from the state register only.
module omsp_lpm_fsm
  import omsp_status_reg_pkg::*;
#(
  parameter bit LPM_EN = 1'b1
) (
  input  logic mclk,
  input  logic puc_rst,
  input  logic cpu_off,
  input  logic dbg_halt_st,
  input  logic wake,
  input  logic lpm_ack,
  output logic lpm_req,
  output logic cpu_en
);

  lpm_state_e state_q;
  lpm_state_e state_d;

  // State register with synchronous reset back to RUN.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= LPM_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a wake seen while still waiting for the ack wins over the
  // ack, so REQ and SLEEP both leave through EXIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LPM_RUN: begin
        if (cpu_off && !dbg_halt_st && !wake) state_d = LPM_REQ;
      end
      LPM_REQ: begin
        if (wake)         state_d = LPM_EXIT;
        else if (lpm_ack) state_d = LPM_SLEEP;
      end
      LPM_SLEEP: begin
        if (wake) state_d = LPM_EXIT;
      end
      LPM_EXIT: begin
        if (!lpm_ack) state_d = LPM_RUN;
      end
      default: state_d = LPM_RUN;
    endcase
    if (!LPM_EN) state_d = LPM_RUN;
  end

  // Output decode from the current state.
  always_comb begin
    cpu_en  = (state_q == LPM_RUN);
    lpm_req = (state_q == LPM_REQ) || (state_q == LPM_SLEEP);
  end

endmodule

// File: rtl/omsp_status_reg.sv
// R2 status register: flag/control storage with irq-entry, register-file
// and ALU update priority, plus the LPM handshake driven from CPUOFF.
module omsp_status_reg
  import omsp_status_reg_pkg::*;
#(
  parameter bit          LPM_EN       = 1'b1,
  parameter logic [15:0] SR_RSVD_MASK = 16'h0000
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [3:0]  alu_stat,
  input  logic [3:0]  alu_stat_wr,
  input  logic        sr_wr,
  input  logic [15:0] sr_wdata,
  input  logic        irq_entry,
  input  logic        irq_pnd,
  input  logic        nmi_pnd,
  input  logic        dbg_halt_st,
  input  logic        dbg_wake,
  input  logic        lpm_ack,
  output logic [3:0]  status,
  output logic [15:0] sr,
  output logic        gie,
  output logic        cpu_off,
  output logic        osc_off,
  output logic        scg0,
  output logic        scg1,
  output logic        lpm_req,
  output logic        cpu_en
);

  localparam logic [15:0] SR_WMASK = SR_ARCH_WMASK | (SR_RSVD_MASK & SR_RSVD_BITS);

  logic [15:0] sr_q;
  logic [15:0] sr_d;
  logic        wake;

  // Priority mux: irq entry, then full register write, then per-flag ALU writes.
  always_comb begin
    sr_d = sr_q;
    if (irq_entry) begin
      sr_d = sr_q & SR_IRQ_KEEP;
    end else if (sr_wr) begin
      sr_d = sr_wdata & SR_WMASK;
    end else begin
      if (alu_stat_wr[0]) sr_d[SR_C] = alu_stat[0];
      if (alu_stat_wr[1]) sr_d[SR_Z] = alu_stat[1];
      if (alu_stat_wr[2]) sr_d[SR_N] = alu_stat[2];
      if (alu_stat_wr[3]) sr_d[SR_V] = alu_stat[3];
    end
  end

  // SR storage; writes become visible the following cycle.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign wake = (irq_pnd & sr_q[SR_GIE]) | nmi_pnd | dbg_wake;

  omsp_lpm_fsm #(
    .LPM_EN (LPM_EN)
  ) u_lpm_fsm (
    .mclk        (mclk),
    .puc_rst     (puc_rst),
    .cpu_off     (sr_q[SR_CPUOFF]),
    .dbg_halt_st (dbg_halt_st),
    .wake        (wake),
    .lpm_ack     (lpm_ack),
    .lpm_req     (lpm_req),
    .cpu_en      (cpu_en)
  );

  // Readback and decoded control bits.
  always_comb begin
    sr      = sr_q;
    status  = sr_flags(sr_q);
    gie     = sr_q[SR_GIE];
    cpu_off = sr_q[SR_CPUOFF];
    osc_off = sr_q[SR_OSCOFF];
    scg0    = sr_q[SR_SCG0];
    scg1    = sr_q[SR_SCG1];
  end

endmodule

// File: tb/tb_omsp_status_reg.sv
// Bench for omsp_status_reg: vector table, hand-written LPM sequences and a
// randomized run against a behavioural model. A second instance with LPM
// disabled and all reserved bits writable shares the stimulus.
module tb_omsp_status_reg;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [3:0]  alu_stat, alu_stat_wr;
  logic        sr_wr;
  logic [15:0] sr_wdata;
  logic        irq_entry, irq_pnd, nmi_pnd, dbg_halt_st, dbg_wake, lpm_ack;

  logic [3:0]  status, status2;
  logic [15:0] sr, sr2;
  logic        gie, cpu_off, osc_off, scg0, scg1, lpm_req, cpu_en;
  logic        gie2, cpu_off2, osc_off2, scg02, scg12, lpm_req2, cpu_en2;

  int total = 0;
  int bad   = 0;

  // Model state: SR value per instance and the handshake seen as outputs.
  logic [15:0] m_sr, m_sr2;
  logic        m_cpu_en, m_lpm_req;

  always #5 mclk = ~mclk;

  omsp_status_reg #(
    .LPM_EN       (1'b1),
    .SR_RSVD_MASK (16'h0000)
  ) dut (
    .mclk(mclk), .puc_rst(puc_rst), .alu_stat(alu_stat), .alu_stat_wr(alu_stat_wr),
    .sr_wr(sr_wr), .sr_wdata(sr_wdata), .irq_entry(irq_entry), .irq_pnd(irq_pnd),
    .nmi_pnd(nmi_pnd), .dbg_halt_st(dbg_halt_st), .dbg_wake(dbg_wake), .lpm_ack(lpm_ack),
    .status(status), .sr(sr), .gie(gie), .cpu_off(cpu_off), .osc_off(osc_off),
    .scg0(scg0), .scg1(scg1), .lpm_req(lpm_req), .cpu_en(cpu_en)
  );

  omsp_status_reg #(
    .LPM_EN       (1'b0),
    .SR_RSVD_MASK (16'hFE00)
  ) dut2 (
    .mclk(mclk), .puc_rst(puc_rst), .alu_stat(alu_stat), .alu_stat_wr(alu_stat_wr),
    .sr_wr(sr_wr), .sr_wdata(sr_wdata), .irq_entry(irq_entry), .irq_pnd(irq_pnd),
    .nmi_pnd(nmi_pnd), .dbg_halt_st(dbg_halt_st), .dbg_wake(dbg_wake), .lpm_ack(lpm_ack),
    .status(status2), .sr(sr2), .gie(gie2), .cpu_off(cpu_off2), .osc_off(osc_off2),
    .scg0(scg02), .scg1(scg12), .lpm_req(lpm_req2), .cpu_en(cpu_en2)
  );

  typedef struct {
    logic        irq_entry;
    logic        sr_wr;
    logic [15:0] sr_wdata;
    logic [3:0]  alu_stat;
    logic [3:0]  alu_stat_wr;
    logic [15:0] exp_sr;
    logic [3:0]  exp_status;
    logic [15:0] exp_sr2;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Next SR from the update rules, given the writable mask of an instance.
  function automatic logic [15:0] sr_next(input logic [15:0] cur, input logic [15:0] wmask);
    logic [15:0] n;
    int unsigned pos;
    n = cur;
    if (irq_entry) begin
      n = cur & 16'h0040;
    end else if (sr_wr) begin
      n = sr_wdata & wmask;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        pos = (i == 3) ? 8 : i;
        if (alu_stat_wr[i]) n[pos] = alu_stat[i];
      end
    end
    return n;
  endfunction

  task automatic model_update();
    logic w;
    if (puc_rst) begin
      m_sr = 16'h0000; m_sr2 = 16'h0000; m_cpu_en = 1'b1; m_lpm_req = 1'b0;
    end else begin
      w = (irq_pnd && m_sr[3]) || nmi_pnd || dbg_wake;
      if (m_cpu_en) begin
        if (m_sr[4] && !dbg_halt_st && !w) begin
          m_cpu_en = 1'b0; m_lpm_req = 1'b1;
        end
      end else if (m_lpm_req) begin
        if (w) m_lpm_req = 1'b0;
      end else if (!lpm_ack) begin
        m_cpu_en = 1'b1;
      end
      m_sr  = sr_next(m_sr, 16'h01FF);
      m_sr2 = sr_next(m_sr2, 16'hFFFF);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    alu_stat = '0; alu_stat_wr = '0; sr_wr = 1'b0; sr_wdata = '0;
    irq_entry = 1'b0; irq_pnd = 1'b0; nmi_pnd = 1'b0;
    dbg_halt_st = 1'b0; dbg_wake = 1'b0; lpm_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
  endtask

  task automatic write_sr(input logic [15:0] v);
    sr_wr = 1'b1; sr_wdata = v;
    step();
    sr_wr = 1'b0; sr_wdata = '0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 4'b1011, 4'b0101, 16'h0001, 4'b0001, 16'h0001};
    vecs[1] = '{1'b0, 1'b1, 16'h01FF, 4'b0000, 4'b1111, 16'h01FF, 4'b1111, 16'h01FF};
    vecs[2] = '{1'b0, 1'b1, 16'h00F9, 4'b0000, 4'b0000, 16'h00F9, 4'b0001, 16'h00F9};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h0040, 4'b0000, 16'h0040};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 4'b0000, 4'b0000, 16'h01FF, 4'b1111, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 4'b1111, 4'b1111, 16'h0040, 4'b0000, 16'h0040};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 4'b1000, 4'b1000, 16'h0140, 4'b1000, 16'h0140};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 4'b0110, 4'b0111, 16'h0146, 4'b1110, 16'h0146};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 4'b1111, 4'b0000, 16'h0146, 4'b1110, 16'h0146};
    vecs[9] = '{1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000};

    do_reset();
    chk("reset_sr", sr, 16'h0000);
    chk("reset_status", {12'h0, status}, 16'h0000);
    chk("reset_ctrl", {11'h0, scg1, scg0, osc_off, cpu_off, gie}, 16'h0000);
    chk("reset_lpm_req", {15'h0, lpm_req}, 16'h0000);
    chk("reset_cpu_en", {15'h0, cpu_en}, 16'h0001);

    // Register update table
    for (int i = 0; i < 10; i++) begin
      irq_entry   = vecs[i].irq_entry;
      sr_wr       = vecs[i].sr_wr;
      sr_wdata    = vecs[i].sr_wdata;
      alu_stat    = vecs[i].alu_stat;
      alu_stat_wr = vecs[i].alu_stat_wr;
      step();
      chk($sformatf("vec%0d_sr", i), sr, vecs[i].exp_sr);
      chk($sformatf("vec%0d_status", i), {12'h0, status}, {12'h0, vecs[i].exp_status});
      chk($sformatf("vec%0d_sr2", i), sr2, vecs[i].exp_sr2);
    end

    // LPM entry/exit with GIE=1, wake on maskable irq
    do_reset();
    write_sr(16'h0018);
    chk("a_run_cpu_en", {15'h0, cpu_en}, 16'h0001);
    step();
    chk("a_req_lpm_req", {15'h0, lpm_req}, 16'h0001);
    chk("a_req_cpu_en", {15'h0, cpu_en}, 16'h0000);
    lpm_ack = 1'b1; step();
    chk("a_sleep_lpm_req", {15'h0, lpm_req}, 16'h0001);
    irq_pnd = 1'b1; step();
    chk("a_exit_lpm_req", {15'h0, lpm_req}, 16'h0000);
    chk("a_exit_cpu_en", {15'h0, cpu_en}, 16'h0000);
    irq_pnd = 1'b0; irq_entry = 1'b1; step();
    irq_entry = 1'b0;
    chk("a_irq_sr", sr, 16'h0000);
    chk("a_exit_hold_cpu_en", {15'h0, cpu_en}, 16'h0000);
    lpm_ack = 1'b0; step();
    chk("a_back_cpu_en", {15'h0, cpu_en}, 16'h0001);
    step();
    chk("a_stay_run", {15'h0, cpu_en}, 16'h0001);

    // GIE=0: irq ignored, clearing CPUOFF in SLEEP does not bypass, nmi wakes
    do_reset();
    write_sr(16'h0010);
    step();
    lpm_ack = 1'b1; step();
    irq_pnd = 1'b1; step();
    chk("b_irq_masked", {15'h0, lpm_req}, 16'h0001);
    write_sr(16'h0000);
    chk("b_clr_cpuoff_req", {15'h0, lpm_req}, 16'h0001);
    chk("b_clr_cpuoff_en", {15'h0, cpu_en}, 16'h0000);
    nmi_pnd = 1'b1; step();
    chk("b_nmi_exit", {15'h0, lpm_req}, 16'h0000);
    nmi_pnd = 1'b0; irq_pnd = 1'b0; lpm_ack = 1'b0; step();
    chk("b_back_cpu_en", {15'h0, cpu_en}, 16'h0001);

    // Debug halt blocks entry from RUN only
    do_reset();
    dbg_halt_st = 1'b1;
    write_sr(16'h0010);
    step(); step();
    chk("c_halt_blocks", {15'h0, lpm_req}, 16'h0000);
    chk("c_halt_cpu_en", {15'h0, cpu_en}, 16'h0001);
    dbg_halt_st = 1'b0; step();
    chk("c_req_after", {15'h0, lpm_req}, 16'h0001);
    dbg_halt_st = 1'b1; step();
    chk("c_halt_in_req", {15'h0, lpm_req}, 16'h0001);
    dbg_halt_st = 1'b0; dbg_wake = 1'b1; step();
    chk("c_dbg_wake", {15'h0, lpm_req}, 16'h0000);
    dbg_wake = 1'b0; step();
    chk("c_back_cpu_en", {15'h0, cpu_en}, 16'h0001);

    // Reset in SLEEP while the clock module still acknowledges
    do_reset();
    write_sr(16'h0018);
    step();
    lpm_ack = 1'b1; step();
    chk("d_sleep", {15'h0, lpm_req}, 16'h0001);
    puc_rst = 1'b1; step();
    chk("d_rst_lpm_req", {15'h0, lpm_req}, 16'h0000);
    chk("d_rst_cpu_en", {15'h0, cpu_en}, 16'h0001);
    chk("d_rst_sr", sr, 16'h0000);
    puc_rst = 1'b0; lpm_ack = 1'b0;

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      puc_rst     = ($urandom_range(63) == 0);
      irq_entry   = ($urandom_range(15) == 0);
      sr_wr       = ($urandom_range(7) == 0);
      sr_wdata    = 16'($urandom);
      alu_stat    = 4'($urandom);
      alu_stat_wr = 4'($urandom);
      irq_pnd     = ($urandom_range(3) == 0);
      nmi_pnd     = ($urandom_range(15) == 0);
      dbg_wake    = ($urandom_range(15) == 0);
      dbg_halt_st = ($urandom_range(3) == 0);
      lpm_ack     = $urandom_range(1) == 1;
      step();
      chk("rnd_sr", sr, m_sr);
      chk("rnd_status", {12'h0, status}, {12'h0, m_sr[8], m_sr[2], m_sr[1], m_sr[0]});
      chk("rnd_ctrl", {11'h0, scg1, scg0, osc_off, cpu_off, gie}, {11'h0, m_sr[7:3]});
      chk("rnd_lpm_req", {15'h0, lpm_req}, {15'h0, m_lpm_req});
      chk("rnd_cpu_en", {15'h0, cpu_en}, {15'h0, m_cpu_en});
      chk("rnd_sr2", sr2, m_sr2);
      chk("rnd_lpm_req2", {15'h0, lpm_req2}, 16'h0000);
      chk("rnd_cpu_en2", {15'h0, cpu_en2}, 16'h0001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
